// File: rtl/bin2bcd_seq.sv
// bin2bcd_seq: sequential shift-and-add-3 binary-to-BCD converter, one bit
// per clock. The result feeds a 4-digit 7-segment driver: BCD0 is the
// thousands digit and BCD3 is the units digit.
// Inputs above MAX_VAL produce all-0xF digits with ovf=1. The display
// blanks non-BCD codes.
// Optional build macro BIN2BCD_LZB_EN enables leading-zero blanking: zero
// digits among BCD0..BCD2, up to the first non-zero digit, become 0xF.
module bin2bcd_seq #(
    parameter int WIDTH   = 14,
    parameter int MAX_VAL = 9999
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [WIDTH-1:0] bin,
    input  logic             start,
    output logic             busy,
    output logic             done,
    output logic             ovf,
    output logic [3:0]       BCD0,
    output logic [3:0]       BCD1,
    output logic [3:0]       BCD2,
    output logic [3:0]       BCD3
);

    localparam int CW = $clog2(WIDTH + 1);
    localparam logic [CW-1:0] LAST_CNT = CW'(WIDTH - 1);
    localparam logic [31:0]   MAXV     = MAX_VAL;

    typedef enum logic [1:0] {S_IDLE, S_SHIFT, S_LOAD} state_t;

    state_t           r_state;
    state_t           w_next;
    logic [WIDTH-1:0] r_sh;
    logic [15:0]      r_acc;
    logic [CW-1:0]    r_cnt;
    logic             r_ovf_next;
    logic             r_ovf;
    logic             r_done;
    logic [15:0]      r_bcd;
    logic [15:0]      w_adj;
    logic [15:0]      w_digits;
    logic             w_ovf_in;

    assign w_ovf_in = {{(32-WIDTH){1'b0}}, bin} > MAXV;

    assign busy = (r_state == S_SHIFT);
    assign done = r_done;
    assign ovf  = r_ovf;
    assign BCD0 = r_bcd[15:12];
    assign BCD1 = r_bcd[11:8];
    assign BCD2 = r_bcd[7:4];
    assign BCD3 = r_bcd[3:0];

    // State register; reset dominates everything, including a same-cycle start.
    always_ff @(posedge clk) begin
        if (reset) r_state <= S_IDLE;
        else       r_state <= w_next;
    end

    // Next-state logic. A start seen outside IDLE is ignored, not queued.
    always_comb begin
        w_next = r_state;
        case (r_state)
            S_IDLE:  if (start) w_next = S_SHIFT;
            S_SHIFT: if (r_cnt == LAST_CNT) w_next = S_LOAD;
            S_LOAD:  w_next = S_IDLE;
            default: w_next = S_IDLE;
        endcase
    end

    // Add-3 correction on every nibble >= 5, applied in parallel before the shift.
    always_comb begin
        w_adj = r_acc;
        for (int g = 0; g < 4; g++) begin
            if (r_acc[4*g +: 4] >= 4'd5) w_adj[4*g +: 4] = r_acc[4*g +: 4] + 4'd3;
        end
    end

    // Output formatting at LOAD: overflow forces all 0xF; optional leading-zero blanking.
    always_comb begin
        w_digits = r_acc;
        if (r_ovf_next) begin
            w_digits = 16'hFFFF;
        end else begin
`ifdef BIN2BCD_LZB_EN
            if (r_acc[15:12] == 4'd0) begin
                w_digits[15:12] = 4'hF;
                if (r_acc[11:8] == 4'd0) begin
                    w_digits[11:8] = 4'hF;
                    if (r_acc[7:4] == 4'd0) w_digits[7:4] = 4'hF;
                end
            end
`else
            w_digits = r_acc;
`endif
        end
    end

    // Datapath: capture on start, then shift. Digits and ovf change only in LOAD.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_sh       <= '0;
            r_acc      <= '0;
            r_cnt      <= '0;
            r_ovf_next <= 1'b0;
            r_ovf      <= 1'b0;
            r_done     <= 1'b0;
            r_bcd      <= '0;
        end else begin
            r_done <= (r_state == S_LOAD);
            case (r_state)
                S_IDLE: begin
                    if (start) begin
                        r_sh       <= bin;
                        r_acc      <= '0;
                        r_cnt      <= '0;
                        r_ovf_next <= w_ovf_in;
                    end
                end
                S_SHIFT: begin
                    // The bit leaving w_adj[15] is discarded; that only happens on overflow.
                    r_acc <= {w_adj[14:0], r_sh[WIDTH-1]};
                    r_sh  <= {r_sh[WIDTH-2:0], 1'b0};
                    r_cnt <= r_cnt + CW'(1);
                end
                S_LOAD: begin
                    r_bcd <= w_digits;
                    r_ovf <= r_ovf_next;
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_bin2bcd_seq.sv
// Self-checking bench for bin2bcd_seq. Expected digits are pushed to a
// scoreboard queue when a conversion is started. A monitor pops and compares
// them on every done pulse.
module tb_bin2bcd_seq;

    logic        clk = 1'b0;
    logic        reset;
    logic [13:0] bin;
    logic        start;
    logic        busy, done, ovf;
    logic [3:0]  BCD0, BCD1, BCD2, BCD3;

    int          vectors     = 0;
    int          miscompares = 0;
    int          cyc         = 0;
    logic [16:0] exp_q[$];
    int          done_cyc[$];

    bin2bcd_seq #(.WIDTH(14), .MAX_VAL(9999)) dut (
        .clk(clk), .reset(reset), .bin(bin), .start(start),
        .busy(busy), .done(done), .ovf(ovf),
        .BCD0(BCD0), .BCD1(BCD1), .BCD2(BCD2), .BCD3(BCD3)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc++;

    // Reference result: {BCD0,BCD1,BCD2,BCD3,ovf} computed by decimal division.
    function automatic logic [16:0] model(input int v);
        logic [3:0] d0, d1, d2, d3;
        if (v > 9999) return {16'hFFFF, 1'b1};
        d0 = 4'(v / 1000);
        d1 = 4'((v / 100) % 10);
        d2 = 4'((v / 10) % 10);
        d3 = 4'(v % 10);
`ifdef BIN2BCD_LZB_EN
        if (d0 == 4'd0) begin
            d0 = 4'hF;
            if (d1 == 4'd0) begin
                d1 = 4'hF;
                if (d2 == 4'd0) d2 = 4'hF;
            end
        end
`endif
        return {d0, d1, d2, d3, 1'b0};
    endfunction

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Monitor: every done pulse must match the oldest outstanding expectation.
    always @(negedge clk) begin
        if (done === 1'b1) begin
            done_cyc.push_back(cyc);
            check("done_expected", 32'(exp_q.size() > 0), 32'd1);
            if (exp_q.size() > 0) begin
                check("result", 32'({BCD0, BCD1, BCD2, BCD3, ovf}), 32'(exp_q.pop_front()));
            end
        end
    end

    task automatic launch(input int v, input bit expect_done);
        @(negedge clk);
        bin   = 14'(v);
        start = 1'b1;
        if (expect_done) exp_q.push_back(model(v));
        @(posedge clk);
        #1 start = 1'b0;
    endtask

    task automatic wait_empty(input int budget);
        int n = 0;
        while (exp_q.size() != 0 && n < budget) begin
            @(negedge clk);
            n++;
        end
        @(negedge clk);
        check("pending_after_timeout", 32'(exp_q.size()), 32'd0);
        exp_q.delete();
    endtask

    initial begin
        int nb;
        int n;
        reset = 1'b1;
        start = 1'b0;
        bin   = '0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        check("reset_state", 32'({busy, done, ovf, BCD0, BCD1, BCD2, BCD3}), 32'd0);
        reset = 1'b0;

        // 1234 with cycle-exact busy/done timing.
        launch(1234, 1'b1);
        for (int i = 0; i < 14; i++) begin
            @(negedge clk);
            check("busy_window", 32'({busy, done}), 32'b10);
        end
        @(negedge clk);
        check("load_cycle", 32'({busy, done}), 32'b00);
        @(negedge clk);
        check("done_pulse", 32'({busy, done}), 32'b01);
        @(negedge clk);
        check("done_one_cycle", 32'(done), 32'd0);

        // Boundary and assorted values.
        launch(0, 1'b1);     wait_empty(40);
        launch(9999, 1'b1);  wait_empty(40);
        launch(10000, 1'b1); wait_empty(40);
        launch(16383, 1'b1); wait_empty(40);
        launch(7, 1'b1);     wait_empty(40);
        launch(80, 1'b1);    wait_empty(40);
        launch(305, 1'b1);   wait_empty(40);
        launch(5000, 1'b1);  wait_empty(40);

        // A start during SHIFT is ignored and produces no second done.
        nb = done_cyc.size();
        launch(56, 1'b1);
        repeat (4) @(negedge clk);
        bin   = 14'd7;
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        wait_empty(40);
        repeat (20) @(negedge clk);
        check("ignored_start_one_done", 32'(done_cyc.size() - nb), 32'd1);
        check("hold_after_ignore", 32'({BCD0, BCD1, BCD2, BCD3, ovf}), 32'(model(56)));

        // Reset mid-conversion aborts with no done pulse.
        nb = done_cyc.size();
        launch(4321, 1'b0);
        repeat (7) @(negedge clk);
        reset = 1'b1;
        @(posedge clk);
        #1 reset = 1'b0;
        @(negedge clk);
        check("abort_state", 32'({busy, done, ovf, BCD0, BCD1, BCD2, BCD3}), 32'd0);
        repeat (25) @(negedge clk);
        check("abort_no_done", 32'(done_cyc.size() - nb), 32'd0);
        launch(4321, 1'b1);  wait_empty(40);

        // Reset and start in the same cycle: start is dropped.
        nb = done_cyc.size();
        @(negedge clk);
        reset = 1'b1;
        start = 1'b1;
        bin   = 14'd99;
        @(posedge clk);
        #1 begin reset = 1'b0; start = 1'b0; end
        @(negedge clk);
        check("reset_beats_start", 32'({busy, done, BCD0, BCD1, BCD2, BCD3}), 32'd0);
        repeat (20) @(negedge clk);
        check("reset_start_no_done", 32'(done_cyc.size() - nb), 32'd0);

        // Start held high: back-to-back conversions every 16 cycles.
        nb = done_cyc.size();
        repeat (3) exp_q.push_back(model(42));
        @(negedge clk);
        bin   = 14'd42;
        start = 1'b1;
        repeat (33) @(posedge clk);
        #1 start = 1'b0;
        n = 0;
        while (exp_q.size() != 0 && n < 100) begin
            @(negedge clk);
            n++;
            if (done_cyc.size() > nb)
                check("b2b_stable", 32'({BCD0, BCD1, BCD2, BCD3, ovf}), 32'(model(42)));
        end
        repeat (20) @(negedge clk);
        check("b2b_count", 32'(done_cyc.size() - nb), 32'd3);
        if (done_cyc.size() >= nb + 3) begin
            check("b2b_period1", 32'(done_cyc[nb+1] - done_cyc[nb]), 32'd16);
            check("b2b_period2", 32'(done_cyc[nb+2] - done_cyc[nb+1]), 32'd16);
        end
        exp_q.delete();

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
